// File: rtl/bp_pht_update_scheduler_pkg.sv
// Shared fetch-unit types for the PHT write path: index/counter widths, the queued
// update entry, and the 2-bit saturating counter step.
package FetchUnitTypes;

  localparam int          PHT_INDEX_WIDTH = 10;
  localparam logic [1:0]  PHT_INIT_VALUE  = 2'b01;

  typedef logic [PHT_INDEX_WIDTH-1:0] PhtIndexPath;
  typedef logic [1:0]                 PhtCounterPath;

  typedef struct packed {
    PhtIndexPath   index;
    PhtCounterPath counter;
  } PhtUpdateEntry;

  typedef enum logic {ST_INIT, ST_RUN} PhtSchedState;

  function automatic PhtCounterPath satUpdate(input PhtCounterPath c, input logic t);
    if (t) return (c == 2'd3) ? c : c + 2'd1;
    else   return (c == 2'd0) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/bp_pht_update_scheduler_queue.sv
// Two-in/one-out FIFO of PHT update entries. A second push in a cycle is only
// issued together with the first, so it always lands in the slot after it.
module pht_update_queue
  import FetchUnitTypes::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push0,
  input  PhtUpdateEntry i_entry0,
  input  logic          i_push1,
  input  PhtUpdateEntry i_entry1,
  input  logic          i_pop,
  output PhtUpdateEntry o_head,
  output logic [CW-1:0] o_count
);

  PhtUpdateEntry r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [PW-1:0] w_wptr1;

  assign w_wptr1 = r_wptr + PW'(1);
  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (i_push0) r_mem[r_wptr]  <= i_entry0;
    if (i_push1) r_mem[w_wptr1] <= i_entry1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= r_wptr + PW'(i_push0) + PW'(i_push1);
      r_rptr  <= r_rptr + PW'(i_pop);
      r_count <= r_count + CW'(i_push0) + CW'(i_push1) - CW'(i_pop);
    end
  end

endmodule

// File: rtl/bp_pht_update_scheduler.sv
// Owns the single PHT write port: sweeps the table to weakly-not-taken after reset,
// then merges up to two commit updates per cycle into a FIFO drained one per cycle.
module bp_pht_update_scheduler
  import FetchUnitTypes::*;
#(
  parameter int QUEUE_DEPTH    = 4,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [1:0]                      updEnable,
  input  logic [1:0][PHT_INDEX_WIDTH-1:0] updIndex,
  input  logic [1:0]                      updTaken,
  input  logic [1:0][1:0]                 updCounter,
  output logic                            updReady,
  output logic                            phtWE,
  output logic [PHT_INDEX_WIDTH-1:0]      phtWA,
  output logic [1:0]                      phtWV,
  output logic                            predReady,
  output logic [DROP_CNT_WIDTH-1:0]       dropCount
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  PhtSchedState      r_state;
  PhtSchedState      w_nextState;
  PhtIndexPath       r_initIdx;
  logic [DROP_CNT_WIDTH-1:0] r_dropCount;

  PhtUpdateEntry     w_head;
  PhtUpdateEntry     w_entry0;
  PhtUpdateEntry     w_entry1;
  logic [CW-1:0]     w_qCount;
  logic [CW-1:0]     w_qFree;
  logic              w_run;
  logic              w_push0;
  logic              w_push1;
  logic              w_pop;
  logic              w_same;
  PhtCounterPath     w_sat0;
  PhtCounterPath     w_sat1;
  PhtCounterPath     w_satC;
  logic [1:0]        w_dropN;
  logic [DROP_CNT_WIDTH:0] w_dropSum;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_INIT;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_INIT: if (r_initIdx == '1) w_nextState = ST_RUN;
      ST_RUN:  w_nextState = ST_RUN;
      default: w_nextState = ST_INIT;
    endcase
  end

  // Everything is held low while rst is high, even if the state register still says RUN.
  always_comb begin
    updReady  = 1'b0;
    predReady = 1'b0;
    phtWE     = 1'b0;
    phtWA     = '0;
    phtWV     = '0;
    if (!rst) begin
      case (r_state)
        ST_INIT: begin
          phtWE = 1'b1;
          phtWA = r_initIdx;
          phtWV = PHT_INIT_VALUE;
        end
        ST_RUN: begin
          predReady = 1'b1;
          updReady  = (w_qFree >= CW'(2));
          if (w_qCount != '0) begin
            phtWE = 1'b1;
            phtWA = w_head.index;
            phtWV = w_head.counter;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                   r_initIdx <= '0;
    else if (r_state == ST_INIT) r_initIdx <= r_initIdx + PHT_INDEX_WIDTH'(1);
  end

  assign w_run   = !rst && (r_state == ST_RUN);
  assign w_qFree = CW'(QUEUE_DEPTH) - w_qCount;
  assign w_pop   = w_run && phtWE;

  // Same-index pairs chain port 1's step onto port 0's result; port 1's counter is stale.
  assign w_sat0 = satUpdate(updCounter[0], updTaken[0]);
  assign w_sat1 = satUpdate(updCounter[1], updTaken[1]);
  assign w_satC = satUpdate(w_sat0, updTaken[1]);
  assign w_same = (&updEnable) && (updIndex[0] == updIndex[1]);

  always_comb begin
    w_push0  = w_run && updReady && (|updEnable);
    w_push1  = w_run && updReady && (&updEnable) && !w_same;
    w_entry1 = '{index: updIndex[1], counter: w_sat1};
    if (updEnable[0]) w_entry0 = '{index: updIndex[0], counter: (w_same ? w_satC : w_sat0)};
    else              w_entry0 = w_entry1;
  end

  pht_update_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk      (clk),
    .rst      (rst),
    .i_push0  (w_push0),
    .i_entry0 (w_entry0),
    .i_push1  (w_push1),
    .i_entry1 (w_entry1),
    .i_pop    (w_pop),
    .o_head   (w_head),
    .o_count  (w_qCount)
  );

  assign w_dropN   = (w_run && !updReady) ? (2'(updEnable[0]) + 2'(updEnable[1])) : 2'd0;
  assign w_dropSum = {1'b0, r_dropCount} + (DROP_CNT_WIDTH+1)'(w_dropN);

  always_ff @(posedge clk) begin
    if (rst)                           r_dropCount <= '0;
    else if (w_dropSum[DROP_CNT_WIDTH]) r_dropCount <= '1;
    else                               r_dropCount <= w_dropSum[DROP_CNT_WIDTH-1:0];
  end

  assign dropCount = r_dropCount;

endmodule

// File: tb/tb_bp_pht_update_scheduler.sv
// Directed bench: init sweep, single/coalesced/paired updates, back-pressure drops,
// mid-run reset, and updates ignored during the sweep.
module tb_bp_pht_update_scheduler;
  import FetchUnitTypes::*;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       updEnable;
  logic [1:0][9:0]  updIndex;
  logic [1:0]       updTaken;
  logic [1:0][1:0]  updCounter;
  logic             updReady;
  logic             phtWE;
  logic [9:0]       phtWA;
  logic [1:0]       phtWV;
  logic             predReady;
  logic [15:0]      dropCount;

  int checks = 0;
  int errors = 0;

  bp_pht_update_scheduler #(.QUEUE_DEPTH(4), .DROP_CNT_WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .updEnable  (updEnable),
    .updIndex   (updIndex),
    .updTaken   (updTaken),
    .updCounter (updCounter),
    .updReady   (updReady),
    .phtWE      (phtWE),
    .phtWA      (phtWA),
    .phtWV      (phtWV),
    .predReady  (predReady),
    .dropCount  (dropCount)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input string tag, input logic [9:0] wa, input logic [1:0] wv, input logic ur);
    chk(tag, 32'({predReady, updReady, phtWE, phtWA, phtWV}), 32'({1'b1, ur, 1'b1, wa, wv}));
  endtask

  task automatic nowr(input string tag, input logic ur);
    chk(tag, 32'({predReady, updReady, phtWE}), 32'({1'b1, ur, 1'b0}));
  endtask

  task automatic drive(input logic [1:0] en,
                       input logic [9:0] i0, input logic [1:0] c0, input logic t0,
                       input logic [9:0] i1, input logic [1:0] c1, input logic t1);
    updEnable     = en;
    updIndex[0]   = i0; updCounter[0] = c0; updTaken[0] = t0;
    updIndex[1]   = i1; updCounter[1] = c1; updTaken[1] = t1;
  endtask

  task automatic idle();
    drive(2'b00, 10'd0, 2'd0, 1'b0, 10'd0, 2'd0, 1'b0);
  endtask

  task automatic sweep(input bit noise);
    for (int i = 0; i < 1024; i++) begin
      if (noise) begin
        updEnable     = 2'($urandom);
        updIndex[0]   = 10'($urandom);
        updIndex[1]   = 10'($urandom);
        updCounter    = 4'($urandom);
        updTaken      = 2'($urandom);
      end
      #1;
      chk("init_sweep", 32'({predReady, updReady, phtWE, phtWA, phtWV}),
          32'({1'b0, 1'b0, 1'b1, 10'(i), 2'b01}));
      @(negedge clk);
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(negedge clk);
    #1;
    chk("reset_outputs", 32'({predReady, updReady, phtWE}), 32'd0);
    chk("reset_drop", 32'(dropCount), 32'd0);
    rst = 1'b0;

    // Test 1: full sweep, then RUN
    sweep(1'b0);
    #1;
    nowr("run_entry", 1'b1);
    chk("run_drop0", 32'(dropCount), 32'd0);
    @(negedge clk);

    // Test 2: single port-0 update saturating up
    drive(2'b01, 10'd5, 2'd3, 1'b1, 10'd0, 2'd0, 1'b0);
    #1; nowr("t2_accept", 1'b1);
    @(negedge clk); idle();
    #1; wr("t2_write", 10'd5, 2'd3, 1'b1);
    @(negedge clk);
    #1; nowr("t2_empty", 1'b1);

    // Test 3: coalesced same-index pairs
    drive(2'b11, 10'd7, 2'd1, 1'b1, 10'd7, 2'd0, 1'b1);
    #1; nowr("t3a_accept", 1'b1);
    @(negedge clk); idle();
    #1; wr("t3a_write", 10'd7, 2'd3, 1'b1);
    @(negedge clk);
    #1; nowr("t3a_single", 1'b1);
    drive(2'b11, 10'd7, 2'd1, 1'b0, 10'd7, 2'd3, 1'b1);
    #1;
    @(negedge clk); idle();
    #1; wr("t3b_write", 10'd7, 2'd1, 1'b1);
    @(negedge clk);
    #1; nowr("t3b_single", 1'b1);

    // Port-1-only update saturating down at zero
    drive(2'b10, 10'd0, 2'd0, 1'b0, 10'd9, 2'd0, 1'b0);
    #1;
    @(negedge clk); idle();
    #1; wr("p1_write", 10'd9, 2'd0, 1'b1);
    @(negedge clk);

    // Test 4: four back-to-back distinct pairs against a depth-4 queue
    drive(2'b11, 10'd10, 2'd2, 1'b1, 10'd11, 2'd1, 1'b0);
    #1; nowr("t4_a", 1'b1);
    @(negedge clk);
    drive(2'b11, 10'd12, 2'd2, 1'b1, 10'd13, 2'd1, 1'b0);
    #1; wr("t4_b", 10'd10, 2'd3, 1'b1);
    @(negedge clk);
    drive(2'b11, 10'd14, 2'd2, 1'b1, 10'd15, 2'd1, 1'b0);
    #1; wr("t4_c", 10'd11, 2'd0, 1'b0);
    @(negedge clk);
    drive(2'b11, 10'd16, 2'd2, 1'b1, 10'd17, 2'd1, 1'b0);
    #1; wr("t4_d", 10'd12, 2'd3, 1'b1);
    chk("t4_drop_d", 32'(dropCount), 32'd2);
    @(negedge clk); idle();
    #1; wr("t4_e", 10'd13, 2'd0, 1'b0);
    @(negedge clk);
    #1; wr("t4_f", 10'd16, 2'd3, 1'b1);
    @(negedge clk);
    #1; wr("t4_g", 10'd17, 2'd0, 1'b1);
    @(negedge clk);
    #1; nowr("t4_h", 1'b1);
    chk("t4_drop_h", 32'(dropCount), 32'd2);
    @(negedge clk);

    // Test 5: reset with three entries pending
    drive(2'b11, 10'd20, 2'd0, 1'b1, 10'd21, 2'd0, 1'b1);
    #1; nowr("t5_fill1", 1'b1);
    @(negedge clk);
    drive(2'b11, 10'd22, 2'd0, 1'b1, 10'd23, 2'd0, 1'b1);
    #1; wr("t5_fill2", 10'd20, 2'd1, 1'b1);
    @(negedge clk); idle();
    rst = 1'b1;
    #1;
    chk("t5_rst_outputs", 32'({predReady, updReady, phtWE}), 32'd0);
    @(negedge clk);
    chk("t5_drop_cleared", 32'(dropCount), 32'd0);
    rst = 1'b0;

    // Test 6: noisy updates during the repeated sweep
    sweep(1'b1);
    #1;
    nowr("t6_run_empty", 1'b1);
    chk("t6_drop", 32'(dropCount), 32'd0);
    @(negedge clk);
    #1; nowr("t6_still_empty", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
